// File: rtl/ppi_bus_sequencer.sv
// Bus master for the ppi block: arbitrates two requesters, issues the ppi reset
// pulse and generates timed rdb/wrb strobes with setup/strobe/hold phases.
module ppi_bus_sequencer #(
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1,
   parameter int RST_CYC    = 3,
   parameter int CNT_W      = 4
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       req0_i,
   input  logic       req1_i,
   input  logic       we0_i,
   input  logic       we1_i,
   input  logic [2:0] addr0_i,
   input  logic [2:0] addr1_i,
   input  logic [7:0] wdata0_i,
   input  logic [7:0] wdata1_i,
   output logic       gnt0_o,
   output logic       gnt1_o,
   output logic       done0_o,
   output logic       done1_o,
   output logic [7:0] rdata_o,
   output logic       busy_o,
   output logic       ppi_rst_o,
   output logic       rdb_o,
   output logic       wrb_o,
   output logic [2:0] address_o,
   output logic [7:0] data_out_o,
   output logic       data_oe_o,
   input  logic [7:0] data_in_i
);

   // state   | meaning
   // INIT    | ppi_rst asserted for RST_CYC cycles after reset release
   // IDLE    | arbitrating between req0 and req1
   // SETUP   | address/data driven, strobes high
   // STROBE  | rdb or wrb low
   // HOLD    | strobes high, address/data held
   // DONE    | one-cycle completion pulse, no arbitration
   typedef enum logic [2:0] {
      ST_INIT, ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_DONE
   } state_t;

   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYC - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sel_q, sel_d;
   logic             prio_q, prio_d;
   logic             we_q, we_d;
   logic [2:0]       addr_q, addr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic             cnt_tc;
   logic             pick1;

   logic       gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic       done0_q, done0_d, done1_q, done1_d;
   logic [7:0] rdata_q, rdata_d;
   logic       busy_q, busy_d, ppi_rst_q, ppi_rst_d;
   logic       rdb_q, rdb_d, wrb_q, wrb_d;
   logic [2:0] address_q, address_d;
   logic [7:0] data_out_q, data_out_d;
   logic       data_oe_q, data_oe_d;
   logic       in_txn;

   assign cnt_tc = (cnt_q == '0);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= ST_INIT;
         cnt_q      <= RST_LD;
         sel_q      <= 1'b0;
         prio_q     <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
         rdata_q    <= '0;
         busy_q     <= 1'b1;
         ppi_rst_q  <= 1'b1;
         rdb_q      <= 1'b1;
         wrb_q      <= 1'b1;
         address_q  <= '0;
         data_out_q <= '0;
         data_oe_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         prio_q     <= prio_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         done0_q    <= done0_d;
         done1_q    <= done1_d;
         rdata_q    <= rdata_d;
         busy_q     <= busy_d;
         ppi_rst_q  <= ppi_rst_d;
         rdb_q      <= rdb_d;
         wrb_q      <= wrb_d;
         address_q  <= address_d;
         data_out_q <= data_out_d;
         data_oe_q  <= data_oe_d;
      end
   end

   // prio_q = 1 means req1 wins a tie (req0 was granted last)
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      prio_d  = prio_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      pick1   = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (cnt_tc) state_d = ST_IDLE;
            else        cnt_d   = cnt_q - 1'b1;
         end
         ST_IDLE: begin
            if (req0_i || req1_i) begin
               pick1   = req1_i && (!req0_i || prio_q);
               sel_d   = pick1;
               prio_d  = !pick1;
               we_d    = pick1 ? we1_i    : we0_i;
               addr_d  = pick1 ? addr1_i  : addr0_i;
               wdata_d = pick1 ? wdata1_i : wdata0_i;
               state_d = ST_SETUP;
               cnt_d   = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (cnt_tc) begin
               state_d = ST_STROBE;
               cnt_d   = STROBE_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_STROBE: begin
            if (cnt_tc) begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_tc) state_d = ST_DONE;
            else        cnt_d   = cnt_q - 1'b1;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_INIT;
      endcase
   end

   // Outputs are decoded from the next state so every port comes straight off a flop.
   always_comb begin
      in_txn     = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
      gnt0_d     = in_txn && !sel_d;
      gnt1_d     = in_txn && sel_d;
      done0_d    = (state_d == ST_DONE) && !sel_d;
      done1_d    = (state_d == ST_DONE) && sel_d;
      rdb_d      = !((state_d == ST_STROBE) && !we_d);
      wrb_d      = !((state_d == ST_STROBE) && we_d);
      data_oe_d  = in_txn && we_d;
      ppi_rst_d  = (state_d == ST_INIT);
      busy_d     = (state_d != ST_IDLE);
      address_d  = address_q;
      data_out_d = data_out_q;
      if ((state_q == ST_IDLE) && (state_d == ST_SETUP)) begin
         address_d  = addr_d;
         data_out_d = wdata_d;
      end
      rdata_d = rdata_q;
      if ((state_q == ST_STROBE) && (state_d == ST_HOLD) && !we_q)
         rdata_d = data_in_i;
   end

   assign gnt0_o     = gnt0_q;
   assign gnt1_o     = gnt1_q;
   assign done0_o    = done0_q;
   assign done1_o    = done1_q;
   assign rdata_o    = rdata_q;
   assign busy_o     = busy_q;
   assign ppi_rst_o  = ppi_rst_q;
   assign rdb_o      = rdb_q;
   assign wrb_o      = wrb_q;
   assign address_o  = address_q;
   assign data_out_o = data_out_q;
   assign data_oe_o  = data_oe_q;

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Bench for ppi_bus_sequencer: directed scenarios then random traffic, checked every
// cycle against a transaction-age reference model.
module tb_ppi_bus_sequencer;

   localparam int S = 2;
   localparam int P = 2;
   localparam int H = 1;
   localparam int R = 3;
   localparam int T = S + P + H;

   logic       clk;
   logic       rst;
   logic       rq [2];
   logic       rwe [2];
   logic [2:0] raddr [2];
   logic [7:0] rwd [2];
   logic [7:0] data_in;

   logic       gnt0_o, gnt1_o, done0_o, done1_o, busy_o, ppi_rst_o, rdb_o, wrb_o, data_oe_o;
   logic [7:0] rdata_o, data_out_o;
   logic [2:0] address_o;

   ppi_bus_sequencer #(
      .SETUP_CYC(S), .STROBE_CYC(P), .HOLD_CYC(H), .RST_CYC(R), .CNT_W(4)
   ) dut (
      .clk_i(clk), .reset_i(rst),
      .req0_i(rq[0]), .req1_i(rq[1]),
      .we0_i(rwe[0]), .we1_i(rwe[1]),
      .addr0_i(raddr[0]), .addr1_i(raddr[1]),
      .wdata0_i(rwd[0]), .wdata1_i(rwd[1]),
      .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
      .done0_o(done0_o), .done1_o(done1_o),
      .rdata_o(rdata_o), .busy_o(busy_o), .ppi_rst_o(ppi_rst_o),
      .rdb_o(rdb_o), .wrb_o(wrb_o), .address_o(address_o),
      .data_out_o(data_out_o), .data_oe_o(data_oe_o), .data_in_i(data_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: tracks boot edges remaining and the age (edges since grant) of the
   // active transaction; every output follows from those by phase arithmetic.
   int         m_boot;
   bit         m_act;
   int         m_age;
   bit         m_sel, m_we, m_last;
   logic [2:0] m_addr;
   logic [7:0] m_wdata, m_rdata;

   bit e_gnt [2];
   bit e_done [2];
   bit e_rdb, e_wrb, e_oe, e_busy, e_rst;

   task automatic model_reset();
      m_boot = R; m_act = 0; m_age = 0; m_sel = 0; m_we = 0; m_last = 1;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
   endtask

   task automatic model_step();
      if (m_boot > 0) begin
         m_boot--;
      end else if (m_act) begin
         if (m_age == S + P && !m_we) m_rdata = data_in;
         m_age++;
         if (m_age == T + 2) m_act = 0;
      end else if (rq[0] || rq[1]) begin
         m_sel   = (rq[0] && rq[1]) ? !m_last : rq[1];
         m_last  = m_sel;
         m_we    = rwe[m_sel];
         m_addr  = raddr[m_sel];
         m_wdata = rwd[m_sel];
         m_act   = 1;
         m_age   = 1;
      end
   endtask

   task automatic model_outputs();
      bit in_t, stb;
      in_t = m_act && m_age <= T;
      stb  = m_act && m_age > S && m_age <= S + P;
      for (int x = 0; x < 2; x++) begin
         e_gnt[x]  = in_t && (int'(m_sel) == x);
         e_done[x] = m_act && m_age == T + 1 && (int'(m_sel) == x);
      end
      e_rdb  = !(stb && !m_we);
      e_wrb  = !(stb && m_we);
      e_oe   = in_t && m_we;
      e_busy = (m_boot > 0) || m_act;
      e_rst  = (m_boot > 0);
   endtask

   task automatic check_all();
      model_outputs();
      chk("gnt0", gnt0_o, e_gnt[0]);
      chk("gnt1", gnt1_o, e_gnt[1]);
      chk("done0", done0_o, e_done[0]);
      chk("done1", done1_o, e_done[1]);
      chk("rdb", rdb_o, e_rdb);
      chk("wrb", wrb_o, e_wrb);
      chk("data_oe", data_oe_o, e_oe);
      chk("busy", busy_o, e_busy);
      chk("ppi_rst", ppi_rst_o, e_rst);
      chk("address", address_o, m_addr);
      chk("data_out", data_out_o, m_wdata);
      chk("rdata", rdata_o, m_rdata);
   endtask

   // Requester behaviour
   bit auto_en, keep_all, drop_en, din_rand;
   bit pend [2];
   int wrb_low_n, rdb_low_n;

   task automatic new_req(input int x);
      rq[x] = 1; pend[x] = 1;
      rwe[x] = 1'($urandom_range(1));
      raddr[x] = 3'($urandom_range(7));
      rwd[x] = 8'($urandom);
   endtask

   task automatic drive();
      for (int x = 0; x < 2; x++) begin
         if (e_done[x]) pend[x] = 0;
         if (auto_en) begin
            if (e_done[x]) begin
               if (keep_all || $urandom_range(1) == 1) new_req(x);
               else rq[x] = 0;
            end else if (!pend[x] && $urandom_range(3) == 0) begin
               new_req(x);
            end else if (drop_en && rq[x] && e_gnt[x] && $urandom_range(15) == 0) begin
               rq[x] = 0;
            end
         end
      end
      if (din_rand) data_in = 8'($urandom);
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
      check_all();
      if (!wrb_o) wrb_low_n++;
      if (!rdb_o) rdb_low_n++;
      drive();
   endtask

   task automatic clear_reqs();
      for (int x = 0; x < 2; x++) begin
         rq[x] = 0; pend[x] = 0;
      end
   endtask

   task automatic do_async_reset();
      #2 rst = 1'b1;
      #1;
      chk("ar_wrb", wrb_o, 1);
      chk("ar_rdb", rdb_o, 1);
      chk("ar_oe", data_oe_o, 0);
      chk("ar_done", {done1_o, done0_o}, 0);
      model_reset();
      clear_reqs();
      @(negedge clk);
      check_all();
      rst = 1'b0;
   endtask

   task automatic run_until_done(input int x, input int limit, input string tag);
      bit seen;
      seen = 0;
      for (int i = 0; i < limit && !seen; i++) begin
         cycle();
         if (e_done[x]) begin
            seen = 1;
            rq[x] = 0;
            pend[x] = 0;
         end
      end
      chk(tag, seen, 1);
   endtask

   initial begin
      int last_w, grants, rise_n, gnt0_after, done_n;
      bit seen, pg0, pg1;

      auto_en = 0; keep_all = 0; drop_en = 0; din_rand = 0;
      data_in = 8'h00;
      clear_reqs();
      for (int x = 0; x < 2; x++) begin
         rwe[x] = 0; raddr[x] = '0; rwd[x] = '0;
      end

      // Boot with req0 write to CWR held from reset
      rst = 1'b1;
      rq[0] = 1; pend[0] = 1; rwe[0] = 1; raddr[0] = 3'o3; rwd[0] = 8'h80;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst = 1'b0;
      wrb_low_n = 0; rdb_low_n = 0;
      run_until_done(0, 20, "wr_done0");
      chk("wr_wrb_low_cycles", wrb_low_n, P);
      chk("wr_rdb_low_cycles", rdb_low_n, 0);

      // req1 read of STATUS returning 5A, then a write must leave rdata alone
      cycle();
      rq[1] = 1; pend[1] = 1; rwe[1] = 0; raddr[1] = 3'o7; data_in = 8'h5A;
      wrb_low_n = 0; rdb_low_n = 0;
      run_until_done(1, 20, "rd_done1");
      chk("rd_rdb_low_cycles", rdb_low_n, P);
      chk("rd_rdata", rdata_o, 8'h5A);
      data_in = 8'h00;
      rq[0] = 1; pend[0] = 1; rwe[0] = 1; raddr[0] = 3'o1; rwd[0] = 8'h3C;
      run_until_done(0, 20, "wr2_done0");
      cycle();
      chk("rdata_hold", rdata_o, 8'h5A);

      // Both held continuously: grants must alternate
      auto_en = 1; keep_all = 1; din_rand = 1;
      new_req(0); new_req(1);
      last_w = -1; grants = 0; pg0 = 0; pg1 = 0;
      for (int i = 0; i < 60; i++) begin
         cycle();
         if ((gnt0_o && !pg0) || (gnt1_o && !pg1)) begin
            if (last_w >= 0) chk("alt_grant", gnt1_o, last_w == 0);
            last_w = gnt1_o ? 1 : 0;
            grants++;
         end
         pg0 = gnt0_o; pg1 = gnt1_o;
      end
      chk("alt_grant_count", grants >= 4, 1);
      auto_en = 0; keep_all = 0; din_rand = 0;
      clear_reqs();
      repeat (T + 3) cycle();

      // Async reset during a write strobe
      rq[0] = 1; pend[0] = 1; rwe[0] = 1; raddr[0] = 3'o2; rwd[0] = 8'hA5;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle();
         if (!wrb_o) seen = 1;
      end
      chk("ar_wrb_seen", seen, 1);
      do_async_reset();
      done_n = 0; rise_n = 0;
      for (int i = 0; i < T + 4; i++) begin
         cycle();
         if (done0_o) done_n++;
         if (ppi_rst_o) rise_n++;
      end
      chk("ar_no_done", done_n, 0);
      chk("ar_ppi_rst_samples", rise_n, R - 1);

      // req0 dropped one cycle after its grant
      rq[0] = 1; pend[0] = 1; rwe[0] = 0; raddr[0] = 3'o5;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         cycle();
         if (e_gnt[0]) seen = 1;
      end
      chk("drop_grant_seen", seen, 1);
      cycle();
      rq[0] = 0;
      run_until_done(0, 12, "drop_done0");
      gnt0_after = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (gnt0_o) gnt0_after++;
      end
      chk("drop_no_regrant", gnt0_after, 0);

      // Random traffic with occasional async resets
      auto_en = 1; drop_en = 1; din_rand = 1;
      for (int i = 0; i < 3000; i++) begin
         cycle();
         if ($urandom_range(299) == 0) do_async_reset();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
